// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// sequenced by a small FSM that stalls the pipeline until a one-cycle done.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   breg;
  logic [2:0]        op;
  logic              neg;

  logic              signeda, signedb, startneg, special;
  logic [XLEN-1:0]   absa, absb, specval;
  logic [XLEN:0]     mulsum, divshift, divtrial;
  logic [2*XLEN-1:0] mulnext, divnext, pfin;
  logic [XLEN-1:0]   divv, dfin, finval;

  assign busy  = (state != S_IDLE);
  assign stall = ((state == S_IDLE) & start & ~flush) | (state == S_RUN) | (state == S_FIN);

  // Operand capture: magnitudes for signed forms, plus the sign the final result must carry.
  always_comb begin
    signeda  = 1'b0;
    signedb  = 1'b0;
    startneg = 1'b0;
    case (func3)
      3'b001, 3'b100: begin
        signeda  = 1'b1;
        signedb  = 1'b1;
        startneg = opA[XLEN-1] ^ opB[XLEN-1];
      end
      3'b010: begin
        signeda  = 1'b1;
        startneg = opA[XLEN-1];
      end
      3'b110: begin
        signeda  = 1'b1;
        signedb  = 1'b1;
        startneg = opA[XLEN-1];
      end
      default: ;
    endcase
    absa = (signeda & opA[XLEN-1]) ? -opA : opA;
    absb = (signedb & opB[XLEN-1]) ? -opB : opB;
  end

  // Divide-by-zero and signed overflow finish immediately without iterating.
  always_comb begin
    special = 1'b0;
    specval = '0;
    if (func3[2] && (opB == '0)) begin
      special = 1'b1;
      specval = func3[1] ? opA : '1;
    end else if (func3[2] && !func3[0] && (opA == MIN_NEG) && (opB == '1)) begin
      special = 1'b1;
      specval = func3[1] ? '0 : opA;
    end
  end

  // One iteration step; acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mulsum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, breg} : {(XLEN+1){1'b0}});
    mulnext  = {mulsum, acc[XLEN-1:1]};
    divshift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    divtrial = divshift - {1'b0, breg};
    if (divtrial[XLEN])
      divnext = {divshift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      divnext = {divtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    pfin = neg ? -acc : acc;
    divv = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    dfin = neg ? -divv : divv;
    if (op[2])
      finval = dfin;
    else if (op[1:0] == 2'b00)
      finval = pfin[XLEN-1:0];
    else
      finval = pfin[2*XLEN-1:XLEN];
  end

  // Sequencer: flush beats start, and done is only ever raised for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      breg   <= '0;
      op     <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op  <= func3;
              neg <= startneg;
              cnt <= '0;
              if (special) begin
                result <= specval;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, absa};
                breg  <= absb;
                state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            acc <= op[2] ? divnext : mulnext;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1))
              state <= S_FIN;
          end
          S_FIN: begin
            result <= finval;
            done   <= 1'b1;
            state  <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results and done cycles are queued at
// start and checked when done pulses; stall/busy are checked every cycle of each op.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, start, flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] opA, opB;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  logic [XLEN-1:0] lastres = '0;

  muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3), .opA(opA), .opB(opB),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [XLEN-1:0] refModel(input logic [2:0] f, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [63:0] u;
    longint      p;
    int          sa, sbv;
    sa  = a;
    sbv = b;
    case (f)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sbv); u = p; return u[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); u = p; return u[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return 32'(sa / sbv);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return 32'(sa % sbv);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == '1));
  endfunction

  // Any done either matches the oldest queued expectation or is unexpected.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("done_cycle", cyc, e.cyc);
      end else begin
        checkOutput("unexpected_done", done, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] f, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] want,
                               input bit hold);
    int   t, lat;
    exp_t e;
    lat = isSpecial(f, a, b) ? 1 : XLEN + 2;
    @(negedge clk);
    start = 1'b1; func3 = f; opA = a; opB = b;
    t = cyc;
    e.res = want; e.cyc = t + lat;
    sb.push_back(e);
    lastres = want;
    #1;
    checkOutput("stall_at_start", stall, 1);
    checkOutput("busy_at_start", busy, 0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold || k == lat) start = 1'b0;
      #1;
      checkOutput("stall", stall, (k < lat));
      checkOutput("busy", busy, 1);
    end
    @(negedge clk);
    #1;
    checkOutput("busy_after", busy, 0);
    checkOutput("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]      rf;
    logic [XLEN-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_stall", stall, 0);
    reset = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    applyStimulus(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    applyStimulus(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    applyStimulus(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);

    // Flush in the tenth RUN cycle: the op is dropped and the old result stays.
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; opA = 32'd9; opB = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_stall", stall, 0);
    checkOutput("flush_done", done, 0);
    checkOutput("flush_result", result, lastres);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("flush_result_later", result, lastres);
    applyStimulus(3'd5, 32'd1000, 32'd10, 32'd100, 1'b0);

    // Reset in the middle of an op clears every output on the next edge.
    @(negedge clk);
    start = 1'b1; func3 = 3'd5; opA = 32'd77; opB = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midreset_result", result, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_stall", stall, 0);
    reset = 1'b0;
    lastres = '0;

    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      applyStimulus(rf, ra, rb, refModel(rf, ra, rb), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
